// File: rtl/bitserializer_pkg.sv
// Shared definitions for the bit-plane serializer: state encoding,
// counter-width rule and precision saturation.
package bitserializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEF_W = 64;
    localparam int DEF_P = 16;

    // Counter and precision fields are clog2(P)+1 wide so that P itself fits.
    function automatic int cnt_w(input int p);
        return $clog2(p) + 1;
    endfunction

    function automatic int sat_prec(input int prec, input int p);
        if (prec < 1) begin
            return 1;
        end else if (prec > p) begin
            return p;
        end else begin
            return prec;
        end
    endfunction

endpackage

// File: rtl/bitserializer_if.sv
// Word-set input and bit-plane output handshakes of the serializer.
interface bitserializer_if
    import bitserializer_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int P = DEF_P
);
    localparam int CW = cnt_w(P);

    logic            in_valid;
    logic            in_ready;
    logic [W*P-1:0]  in_data;
    logic [CW-1:0]   in_prec;
    logic            in_msbfirst;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_bits;
    logic            out_first;
    logic            out_last;

    modport master (
        output in_valid, in_data, in_prec, in_msbfirst, out_ready,
        input  in_ready, out_valid, out_bits, out_first, out_last
    );

    modport slave (
        input  in_valid, in_data, in_prec, in_msbfirst, out_ready,
        output in_ready, out_valid, out_bits, out_first, out_last
    );

endinterface

// File: rtl/bitserializer_serlane.sv
// One lane: P-bit loadable shift register that emits a single bit per plane
// from the end selected by the shift direction.
module bitserializer_serlane #(
    parameter int P  = 16,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load_i,
    input  logic          shift_i,
    input  logic          msbfirst_i,
    input  logic [CW-1:0] shamt_i,
    input  logic [P-1:0]  data_i,
    output logic          bit_o
);
    logic [P-1:0] sh_q;
    logic [P-1:0] sh_d;

    // MSB-first words are pre-aligned on load so bit prec-1 sits at the top.
    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = data_i << shamt_i;
        end else if (shift_i) begin
            sh_d = msbfirst_i ? (sh_q << 1'b1) : (sh_q >> 1'b1);
        end else begin
            sh_d = sh_q;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sh_q <= {P{1'b0}};
        end else begin
            sh_q <= sh_d;
        end
    end

    assign bit_o = msbfirst_i ? sh_q[P-1] : sh_q[0];

endmodule

// File: rtl/bitserializer.sv
// Serializes W parallel lane words of up to P bits into bit planes,
// one plane per consume, MSB- or LSB-first per set.
module bitserializer
    import bitserializer_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int P = DEF_P
) (
    input  logic            clk,
    input  logic            clr,
    bitserializer_if.slave  bus
);
    localparam int CW = cnt_w(P);
    localparam logic [CW-1:0] P_C = CW'(P);

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic           msb_q;
    logic           first_q;

    logic [CW-1:0]  prec_eff_s;
    logic [CW-1:0]  shamt_s;
    logic           last_s;
    logic           accept_s;
    logic           consume_s;
    logic           shift_s;
    logic [W-1:0]   bits_s;

    assign last_s    = (state_q == SHIFT) && (cnt_q == {CW{1'b0}});
    assign consume_s = (state_q == SHIFT) && bus.out_ready;
    assign accept_s  = bus.in_valid && bus.in_ready;
    assign shift_s   = consume_s && !last_s;

    // in_ready follows out_ready combinationally only on the last plane,
    // which is what allows a new set to follow with no bubble.
    assign bus.in_ready = !clr && ((state_q == IDLE) || (last_s && bus.out_ready));

    // Saturated precision and the MSB-first alignment it implies.
    always_comb begin
        prec_eff_s = CW'(sat_prec(int'(bus.in_prec), P));
        if (bus.in_msbfirst) begin
            shamt_s = P_C - prec_eff_s;
        end else begin
            shamt_s = {CW{1'b0}};
        end
    end

    // Set sequencing FSM: plane counter, bit order and first-plane flag.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            msb_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        state_q <= SHIFT;
                        cnt_q   <= prec_eff_s - {{(CW-1){1'b0}}, 1'b1};
                        msb_q   <= bus.in_msbfirst;
                        first_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (accept_s) begin
                        cnt_q   <= prec_eff_s - {{(CW-1){1'b0}}, 1'b1};
                        msb_q   <= bus.in_msbfirst;
                        first_q <= 1'b1;
                    end else if (consume_s) begin
                        first_q <= 1'b0;
                        if (last_s) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= {CW{1'b0}};
                    first_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_lane
        bitserializer_serlane #(
            .P  (P),
            .CW (CW)
        ) u_serlane (
            .clk        (clk),
            .clr        (clr),
            .load_i     (accept_s),
            .shift_i    (shift_s),
            .msbfirst_i (msb_q),
            .shamt_i    (shamt_s),
            .data_i     (bus.in_data[i*P +: P]),
            .bit_o      (bits_s[i])
        );
    end

    assign bus.out_valid = (state_q == SHIFT);
    assign bus.out_first = (state_q == SHIFT) && first_q;
    assign bus.out_last  = last_s;
    assign bus.out_bits  = bits_s;

endmodule

// File: tb/tb_bitserializer.sv
// Directed and randomized checks of the bit-plane serializer against a
// plane-queue reference model.
module tb_bitserializer;
    localparam int W = 4;
    localparam int P = 4;

    typedef struct {
        logic [W-1:0] bits;
        logic         first;
        logic         last;
    } plane_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    plane_t q[$];
    plane_t log_q[$];

    bitserializer_if #(.W(W), .P(P)) bus ();

    bitserializer #(.W(W), .P(P)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected planes of one set, derived directly from the lane words.
    task automatic model_push(input logic [W*P-1:0] d, input int pr, input logic msb);
        int pe;
        int idx;
        plane_t e;
        pe = (pr == 0) ? 1 : ((pr > P) ? P : pr);
        for (int k = 0; k < pe; k++) begin
            idx = msb ? (pe - 1 - k) : k;
            for (int i = 0; i < W; i++) e.bits[i] = d[i*P + idx];
            e.first = (k == 0);
            e.last  = (k == pe - 1);
            q.push_back(e);
        end
    endtask

    task automatic step(input logic v, input logic [W*P-1:0] d, input int pr,
                        input logic msb, input logic ordy);
        plane_t obs;
        logic   exp_rdy;
        @(negedge clk);
        bus.in_valid    = v;
        bus.in_data     = d;
        bus.in_prec     = 3'(pr);
        bus.in_msbfirst = msb;
        bus.out_ready   = ordy;
        #1;
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk("out_bits",  {28'd0, bus.out_bits}, {28'd0, q[0].bits});
            chk("out_first", {31'd0, bus.out_first}, {31'd0, q[0].first});
            chk("out_last",  {31'd0, bus.out_last},  {31'd0, q[0].last});
        end
        exp_rdy = (q.size() == 0) || (q.size() == 1 && ordy);
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        if (q.size() > 0 && ordy) begin
            obs.bits  = bus.out_bits;
            obs.first = bus.out_first;
            obs.last  = bus.out_last;
            log_q.push_back(obs);
            void'(q.pop_front());
        end
        if (v && exp_rdy) model_push(d, pr, msb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_data     = 16'h0000;
        bus.in_prec     = 3'd0;
        bus.in_msbfirst = 1'b0;
        bus.out_ready   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_bits",  {28'd0, bus.out_bits},  32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("rst_out_last",  {31'd0, bus.out_last},  32'd0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // MSB-first, prec 4, lanes A,5,F,0
        log_q.delete();
        step(1'b1, 16'h0F5A, 4, 1'b1, 1'b1);
        idle(5);
        chk("msb_count", log_q.size(), 32'd4);
        if (log_q.size() == 4) begin
            chk("msb_p0", {28'd0, log_q[0].bits}, 32'h5);
            chk("msb_p1", {28'd0, log_q[1].bits}, 32'h6);
            chk("msb_p2", {28'd0, log_q[2].bits}, 32'h5);
            chk("msb_p3", {28'd0, log_q[3].bits}, 32'h6);
            chk("msb_first", {31'd0, log_q[0].first}, 32'd1);
            chk("msb_last",  {31'd0, log_q[3].last},  32'd1);
        end

        // LSB-first, prec 2, lane0 = 2
        log_q.delete();
        step(1'b1, 16'h0002, 2, 1'b0, 1'b1);
        idle(3);
        chk("lsb_count", log_q.size(), 32'd2);
        if (log_q.size() == 2) begin
            chk("lsb_b0", {31'd0, log_q[0].bits[0]}, 32'd0);
            chk("lsb_b1", {31'd0, log_q[1].bits[0]}, 32'd1);
            chk("lsb_fl", {30'd0, log_q[0].first, log_q[1].last}, 32'd3);
        end

        // Back-to-back sets with in_valid held high
        for (int i = 0; i < 16; i++)
            step(1'b1, 16'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 1'b1);
        idle(6);

        // Stall three cycles on plane 1
        log_q.delete();
        step(1'b1, 16'h9C3E, 4, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 0, 1'b0, 1'b1);
        repeat (3) step(1'b1, 16'hFFFF, 1, 1'b0, 1'b0);
        idle(5);
        chk("stall_count", log_q.size(), 32'd4);

        // Precision edges
        log_q.delete();
        step(1'b1, 16'h1111, 0, 1'b1, 1'b1);
        idle(3);
        chk("prec0_count", log_q.size(), 32'd1);
        if (log_q.size() == 1)
            chk("prec0_fl", {30'd0, log_q[0].first, log_q[0].last}, 32'd3);
        log_q.delete();
        step(1'b1, 16'hA5C3, 7, 1'b0, 1'b1);
        idle(6);
        chk("prec7_count", log_q.size(), 32'd4);

        // Reset mid-set during plane 2, then a fresh set
        step(1'b1, 16'h3C5A, 4, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 0, 1'b0, 1'b1);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.in_ready},  32'd0);
        q.delete();
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("mid_rel_ready", {31'd0, bus.in_ready}, 32'd1);
        log_q.delete();
        step(1'b1, 16'h6B2D, 3, 1'b1, 1'b1);
        idle(5);
        chk("post_rst_count", log_q.size(), 32'd3);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 16'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
                 ($urandom_range(0, 3) != 0));
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
